// File: rtl/seg7_to_ascii.sv
// rtl/seg7_to_ascii.sv - seven-segment pattern debouncer and decoder feeding a FWFT ASCII FIFO
module seg7_to_ascii #(
    parameter int STABLE_CNT = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       seg_strobe,
    input  logic       out_ready,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    output logic [4:0] fifo_count,
    output logic       overflow
);

    localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] STABLE_C = 4'(STABLE_CNT);
    localparam logic [4:0] DEPTH_C  = 5'(FIFO_DEPTH);
    localparam logic [6:0] BLANK_P  = 7'h7F;

    typedef enum logic [1:0] {ST_BLANK, ST_QUAL, ST_HELD} state_t;

    state_t          state_q, state_d;
    logic [6:0]      last_q, last_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      cnt_upd;
    logic            same, blank, push;
    logic [7:0]      push_char;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [4:0]      count_q;
    logic            overflow_q;
    logic            pop, full, do_push;

    function automatic logic [7:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 8'h30;
            7'h79:   decode = 8'h31;
            7'h24:   decode = 8'h32;
            7'h30:   decode = 8'h33;
            7'h19:   decode = 8'h34;
            7'h12:   decode = 8'h35;
            7'h02:   decode = 8'h36;
            7'h78:   decode = 8'h37;
            7'h00:   decode = 8'h38;
            7'h10:   decode = 8'h39;
            default: decode = 8'h3F;
        endcase
    endfunction

    assign same      = (seg_in == last_q);
    assign blank     = (seg_in == BLANK_P);
    assign cnt_upd   = same ? ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1) : 4'd1;
    assign push_char = decode(seg_in);

    // A HELD pattern never re-pushes; only a different or blank sample re-arms it.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (seg_strobe) begin
            last_d = seg_in;
            cnt_d  = cnt_upd;
            if (blank) begin
                state_d = ST_BLANK;
            end else if (state_q == ST_HELD && same) begin
                state_d = ST_HELD;
            end else if (cnt_upd == STABLE_C) begin
                push    = 1'b1;
                state_d = ST_HELD;
            end else begin
                state_d = ST_QUAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            last_q  <= BLANK_P;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop     = ascii_valid & out_ready;
    assign full    = (count_q == DEPTH_C);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            case ({do_push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign ascii_valid = (count_q != 5'd0);
    assign ascii_out   = ascii_valid ? mem_q[rd_q] : 8'h00;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;

endmodule
